// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: slave FSM states and default slot/reset timing
// (25 MHz clock), so the master and slave ends agree on the same numbers.
package onewire_pkg;

    localparam int OW_SAMPLE_CYC    = 750;
    localparam int OW_TX_HOLD_CYC   = 750;
    localparam int OW_RST_MIN_CYC   = 10000;
    localparam int OW_PRES_WAIT_CYC = 750;
    localparam int OW_PRES_CYC      = 3000;
    localparam int OW_CNT_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SLOT       = 3'd1,
        ST_TX0_HOLD   = 3'd2,
        ST_WAIT_HIGH  = 3'd3,
        ST_RST_LOW    = 3'd4,
        ST_PRES_WAIT  = 3'd5,
        ST_PRES_DRIVE = 3'd6,
        ST_PRES_REL   = 3'd7
    } ow_state_e;

    function automatic logic ow_is_pres(input ow_state_e s);
        return (s == ST_PRES_WAIT) || (s == ST_PRES_DRIVE) || (s == ST_PRES_REL);
    endfunction

endpackage

// File: rtl/onewire_in_sync.sv
// Two-flop synchronizer for the 1-Wire bus line plus one-cycle fall/rise strobes.
module onewire_in_sync (
    input  logic clk,
    input  logic n_rst,
    input  logic wire_in,
    output logic line,
    output logic fall,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = wire_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset to the idle (pulled-up) level so reset release never looks like a fall.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign line = sync_q;
    assign fall = prev_q & ~sync_q;
    assign rise = ~prev_q & sync_q;

endmodule

// File: rtl/onewire_slave.sv
// 1-Wire device-end responder: reset/presence handling, LSB-first write-slot
// receive and read-slot transmit of a loaded byte.
//
//  state         | meaning
//  --------------+---------------------------------------------------------
//  ST_IDLE       | line high, waiting for a master falling edge
//  ST_SLOT       | receive slot or transmit '1' slot, line left released
//  ST_TX0_HOLD   | transmit '0': slave holds the line low
//  ST_WAIT_HIGH  | transmit '0' done, waiting for the line to return high
//  ST_RST_LOW    | bus reset classified, waiting for master release
//  ST_PRES_WAIT  | gap between reset release and presence pulse
//  ST_PRES_DRIVE | presence pulse, slave holds the line low
//  ST_PRES_REL   | presence released, waiting for synced line high
module onewire_slave
    import onewire_pkg::*;
#(
    parameter int SAMPLE_CYC    = OW_SAMPLE_CYC,
    parameter int TX_HOLD_CYC   = OW_TX_HOLD_CYC,
    parameter int RST_MIN_CYC   = OW_RST_MIN_CYC,
    parameter int PRES_WAIT_CYC = OW_PRES_WAIT_CYC,
    parameter int PRES_CYC      = OW_PRES_CYC,
    parameter int CNT_W         = OW_CNT_W
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       wire_in,
    output logic       pull_low,
    input  logic [7:0] tx_byte,
    input  logic       tx_load,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       reset_det
);

    localparam logic [CNT_W-1:0] SAMPLE_C      = CNT_W'(SAMPLE_CYC);
    localparam logic [CNT_W-1:0] HOLD_C        = CNT_W'(TX_HOLD_CYC);
    localparam logic [CNT_W-1:0] RST_C         = CNT_W'(RST_MIN_CYC);
    localparam logic [CNT_W-1:0] PWAIT_LAST_C  = CNT_W'(PRES_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] PDRIVE_LAST_C = CNT_W'(PRES_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;

    logic line, fall, rise;

    ow_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic             tx_busy_q, tx_busy_d;
    logic             slot_tx_q, slot_tx_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_done_q, tx_done_d;
    logic             reset_det_q, reset_det_d;

    logic bit_evt, bit_val, rst_entry, load_ok;

    onewire_in_sync u_sync (
        .clk     (clk),
        .n_rst   (n_rst),
        .wire_in (wire_in),
        .line    (line),
        .fall    (fall),
        .rise    (rise)
    );

    // Saturating so a very long low can never wrap back onto the sample point.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_inc;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        tx_busy_d   = tx_busy_q;
        slot_tx_d   = slot_tx_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        tx_done_d   = 1'b0;
        reset_det_d = 1'b0;
        bit_evt     = 1'b0;
        bit_val     = 1'b0;
        rst_entry   = 1'b0;
        load_ok     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    cnt_d     = '0;
                    slot_tx_d = tx_busy_q;
                    state_d   = (tx_busy_q && !tx_sh_q[0]) ? ST_TX0_HOLD : ST_SLOT;
                end
            end
            ST_SLOT: begin
                // A rise landing exactly on the sample point still counts as a '1'.
                if (rise) begin
                    if (cnt_q <= SAMPLE_C) begin
                        bit_evt = 1'b1;
                        bit_val = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (cnt_q == SAMPLE_C) begin
                    bit_evt = 1'b1;
                    bit_val = 1'b0;
                end else if (cnt_q >= RST_C) begin
                    state_d = ST_RST_LOW;
                end
            end
            ST_TX0_HOLD: begin
                if (cnt_q == HOLD_C) begin
                    bit_evt = 1'b1;
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (line) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= RST_C) begin
                    state_d = ST_RST_LOW;
                end
            end
            ST_RST_LOW: begin
                if (line) begin
                    state_d = ST_PRES_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRES_WAIT: begin
                if (cnt_q == PWAIT_LAST_C) begin
                    state_d = ST_PRES_DRIVE;
                    cnt_d   = '0;
                end
            end
            ST_PRES_DRIVE: begin
                if (cnt_q == PDRIVE_LAST_C) begin
                    state_d = ST_PRES_REL;
                    cnt_d   = '0;
                end
            end
            ST_PRES_REL: begin
                if (line) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bit_evt) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (slot_tx_q) begin
                tx_sh_d = {1'b0, tx_sh_q[7:1]};
                if (bit_cnt_q == 3'd7) begin
                    tx_busy_d = 1'b0;
                    tx_done_d = 1'b1;
                end
            end else begin
                rx_sh_d = {bit_val, rx_sh_q[7:1]};
                if (bit_cnt_q == 3'd7) begin
                    rx_byte_d  = {bit_val, rx_sh_q[7:1]};
                    rx_valid_d = 1'b1;
                end
            end
        end

        rst_entry = (state_d == ST_RST_LOW) && (state_q != ST_RST_LOW);
        if (rst_entry) begin
            reset_det_d = 1'b1;
            bit_cnt_d   = '0;
            rx_sh_d     = '0;
            tx_busy_d   = 1'b0;
        end

        // Reset classification in the same cycle wins over a load.
        load_ok = tx_load && !tx_busy_q && !ow_is_pres(state_q)
                  && (state_q != ST_RST_LOW) && !rst_entry;
        if (load_ok) begin
            tx_sh_d   = tx_byte;
            tx_busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            tx_busy_q   <= 1'b0;
            slot_tx_q   <= 1'b0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            reset_det_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            tx_busy_q   <= tx_busy_d;
            slot_tx_q   <= slot_tx_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            tx_done_q   <= tx_done_d;
            reset_det_q <= reset_det_d;
        end
    end

    // Decoded from state so an async reset releases the bus immediately.
    assign pull_low  = (state_q == ST_TX0_HOLD) || (state_q == ST_PRES_DRIVE);
    assign tx_busy   = tx_busy_q;
    assign tx_done   = tx_done_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign reset_det = reset_det_q;

endmodule
